// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the tick generator.
// States, divided-clock bus width and default widths.
package tick_gen_pkg;

    localparam int DIV_W           = 32;
    localparam int SEL_W_DEFAULT   = 5;
    localparam int COUNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } tick_state_t;

endpackage

// File: rtl/tick_generator_rise_detect.sv
// Registered previous-bit tracker with a load override.
// rise is high when the tracked bit is 1 and was 0 last cycle.
module rise_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic bit_in,
    input  logic load,
    input  logic load_val,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = bit_in;
        if (load) begin
            prev_d = load_val;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = bit_in & ~prev_q;

endmodule

// File: rtl/tick_generator.sv
// Turns rising edges of a selected divided-clock bit into one-cycle ticks.
// Define TICK_COUNT_EN to build the wrapping tick counter; else tick_count is 0.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEFAULT,
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DIV_W-1:0]   divided_clocks,
    input  logic [SEL_W-1:0]   sel,
    input  logic               enable,
    input  logic               step,
    output logic               tick,
    output logic [SEL_W-1:0]   sel_active,
    output logic               switching,
    output logic [COUNT_W-1:0] tick_count
);

    tick_state_t      state_q;
    tick_state_t      state_d;
    logic             tick_q;
    logic             tick_d;
    logic [SEL_W-1:0] sel_active_q;
    logic [SEL_W-1:0] sel_active_d;
    logic             cur_bit;
    logic             rise;
    logic             in_switch;
    logic             sel_change;

    assign cur_bit    = divided_clocks[sel_active_q];
    assign in_switch  = (state_q == SWITCH);
    assign sel_change = (sel != sel_active_q);

    // sel_active already holds the new index while in SWITCH
    rise_detect u_rise (
        .clock    (clock),
        .reset_n  (reset_n),
        .bit_in   (cur_bit),
        .load     (in_switch),
        .load_val (divided_clocks[sel_active_q]),
        .rise     (rise)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = 1'b0;
        sel_active_d = sel_active_q;
        unique case (state_q)
            IDLE: begin
                if (sel_change) begin
                    state_d      = SWITCH;
                    sel_active_d = sel;
                end else begin
                    tick_d = step;
                    if (enable) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (sel_change) begin
                    state_d      = SWITCH;
                    sel_active_d = sel;
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    tick_d = rise;
                end
            end
            SWITCH: begin
                state_d = enable ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_q       <= 1'b0;
            sel_active_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            sel_active_q <= sel_active_d;
        end
    end

`ifdef TICK_COUNT_EN
    logic [COUNT_W-1:0] tick_count_q;
    logic [COUNT_W-1:0] tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q;
        if (tick_q) begin
            tick_count_d = tick_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`else
    assign tick_count = '0;
`endif

    assign tick       = tick_q;
    assign sel_active = sel_active_q;
    assign switching  = in_switch;

endmodule

// File: tb/tb_tick_generator.sv
// Directed scoreboard bench for tick_generator (COUNT_W=4).
// A cycle model pushes expected outputs; each edge pops and compares.
module tb_tick_generator;

    localparam int CW = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_SW   = 2;

    typedef struct packed {
        logic          tk;
        logic [4:0]    sa;
        logic          sw;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic [31:0]   dc;
    logic [4:0]    sel;
    logic          enable;
    logic          step;
    logic          tick;
    logic [4:0]    sel_active;
    logic          switching;
    logic [CW-1:0] tick_count;

    int n_chk;
    int n_pass;
    int ticks_seen;

    int            m_st;
    logic          m_prev;
    logic [4:0]    m_sel;
    logic          m_tick;
    logic [CW-1:0] m_cnt;

    exp_t q[$];

    tick_generator #(
        .SEL_W   (5),
        .COUNT_W (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .divided_clocks (dc),
        .sel            (sel),
        .enable         (enable),
        .step           (step),
        .tick           (tick),
        .sel_active     (sel_active),
        .switching      (switching),
        .tick_count     (tick_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [CW-1:0] exp_cnt();
`ifdef TICK_COUNT_EN
        return m_cnt;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_st   = S_IDLE;
        m_prev = 1'b0;
        m_sel  = '0;
        m_tick = 1'b0;
        m_cnt  = '0;
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_step();
        logic cur;
        logic rs;
        int   n_st;
        logic n_tick;
        logic [4:0] n_sel;
        cur    = dc[m_sel];
        rs     = cur & ~m_prev;
        n_st   = m_st;
        n_tick = 1'b0;
        n_sel  = m_sel;
        if (m_st == S_SW) begin
            n_st = enable ? S_RUN : S_IDLE;
        end else if (sel != m_sel) begin
            n_st  = S_SW;
            n_sel = sel;
        end else if (m_st == S_IDLE) begin
            n_tick = step;
            if (enable) n_st = S_RUN;
        end else if (!enable) begin
            n_st = S_IDLE;
        end else begin
            n_tick = rs;
        end
        m_cnt  = m_cnt + CW'(m_tick);
        m_prev = cur;
        m_tick = n_tick;
        m_sel  = n_sel;
        m_st   = n_st;
    endtask

    function automatic logic model_rise();
        return (m_st == S_RUN) && dc[m_sel] && !m_prev;
    endfunction

    task automatic cyc();
        exp_t e;
        model_step();
        e.tk  = m_tick;
        e.sa  = m_sel;
        e.sw  = (m_st == S_SW);
        e.cnt = exp_cnt();
        q.push_back(e);
        @(posedge clock);
        #1;
        e = q.pop_front();
        chk("tick", 32'(tick), 32'(e.tk));
        chk("sel_active", 32'(sel_active), 32'(e.sa));
        chk("switching", 32'(switching), 32'(e.sw));
        chk("tick_count", 32'(tick_count), 32'(e.cnt));
        if (tick) ticks_seen++;
        dc = dc + 1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        ticks_seen = 0;
        dc = '0;
        sel = '0;
        enable = 1'b0;
        step = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #2 reset_n = 1'b0;
        #10;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_sel", 32'(sel_active), 0);
        chk("rst_sw", 32'(switching), 0);
        chk("rst_cnt", 32'(tick_count), 0);
        @(posedge clock);
        #1;

        // Free run on bit 0
        reset_n = 1'b1;
        enable = 1'b1;
        ticks_seen = 0;
        repeat (21) cyc();
        chk("p1_ticks", ticks_seen, 10);
`ifdef TICK_COUNT_EN
        chk("p1_count", 32'(tick_count), 10);
`else
        chk("p1_count", 32'(tick_count), 0);
`endif

        // Bit 2: one tick every 8 cycles
        sel = 5'd2;
        cyc();
        chk("sw2_flag", 32'(switching), 1);
        cyc();
        chk("sw2_sel", 32'(sel_active), 2);
        ticks_seen = 0;
        repeat (32) cyc();
        chk("p2_ticks", ticks_seen, 4);

        // Switch to bit 0 exactly on a rise of bit 2
        for (int i = 0; i < 16 && !model_rise(); i++) cyc();
        chk("rise_pending", 32'(model_rise()), 1);
        sel = 5'd0;
        cyc();
        chk("sw0_tick", 32'(tick), 0);
        chk("sw0_flag", 32'(switching), 1);
        cyc();
        chk("sw0_sel", 32'(sel_active), 0);
        chk("sw0_done", 32'(switching), 0);
        ticks_seen = 0;
        repeat (10) cyc();
        chk("p3_ticks", ticks_seen, 5);

        // Disable and reselect together: SWITCH, then IDLE
        enable = 1'b0;
        sel = 5'd4;
        cyc();
        chk("sw4_flag", 32'(switching), 1);
        ticks_seen = 0;
        repeat (20) cyc();
        chk("idle_ticks", ticks_seen, 0);

        // Three single steps while paused
        ticks_seen = 0;
        repeat (3) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            chk("step_tick", 32'(tick), 1);
            repeat (4) cyc();
        end
        chk("step_ticks", ticks_seen, 3);

        // Run on bit 4, then reset between edges
        enable = 1'b1;
        repeat (40) cyc();
        chk("pre_rst_sel", 32'(sel_active), 4);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_tick", 32'(tick), 0);
        chk("arst_sel", 32'(sel_active), 0);
        chk("arst_cnt", 32'(tick_count), 0);
        chk("arst_sw", 32'(switching), 0);
        repeat (2) begin
            @(posedge clock);
            #1;
            dc = dc + 1;
        end
        sel = 5'd0;
        reset_n = 1'b1;

        // 17 ticks wrap the 4-bit counter to 1
        ticks_seen = 0;
        for (int i = 0; i < 80 && ticks_seen < 17; i++) cyc();
        chk("wrap_ticks", ticks_seen, 17);
        cyc();
`ifdef TICK_COUNT_EN
        chk("wrap_count", 32'(tick_count), 1);
`else
        chk("wrap_count", 32'(tick_count), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
